// File: rtl/bandpower_reader.sv
// bandpower_reader: snapshots the bandpower engine's BAND_NUM result words on
// each rising i_done and streams them out one word per valid/ready beat with
// band index and last flag. One additional frame can wait in a pending buffer
// while a frame is streaming; any further frame arriving then is dropped and
// counted. Data registers carry no reset; every data output is gated by the
// streaming state, so all outputs read 0 while reset is asserted.
// Optional: define BANDPOWER_READER_PEAK_EN to add per-frame peak band outputs.
module bandpower_reader #(
  parameter int WIDTH    = 12,
  parameter int BAND_NUM = 2,
  parameter int CNT_W    = 8,
  localparam int IDX_W   = (BAND_NUM > 1) ? $clog2(BAND_NUM) : 1
) (
  input  logic                           i_sys_clk,
  input  logic                           i_sys_rst,
  // Band b occupies i_y[b]; each word is two's complement.
  input  logic [BAND_NUM-1:0][WIDTH-1:0] i_y,
  input  logic                           i_done,
  output logic signed [WIDTH-1:0]        o_data,
  output logic [IDX_W-1:0]               o_idx,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic                           o_last,
  output logic                           o_busy,
  output logic [CNT_W-1:0]               o_drop_cnt,
  output logic [CNT_W-1:0]               o_frame_cnt
`ifdef BANDPOWER_READER_PEAK_EN
  ,
  output logic [IDX_W-1:0]               o_peak_idx,
  output logic signed [WIDTH-1:0]        o_peak_val
`endif
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_done_q;
  logic                    r_armed;
  logic                    w_rise;
  logic [IDX_W-1:0]        r_idx, w_idx_nxt;
  logic                    r_pend_full, w_pend_full_nxt;
  logic [CNT_W-1:0]        r_drop_cnt;
  logic [CNT_W-1:0]        r_frame_cnt;
  logic                    w_beat;
  logic                    w_last;
  logic                    w_send;
  logic                    w_ld_act_y;
  logic                    w_ld_act_pend;
  logic                    w_ld_pend;
  logic                    w_frame_inc;
  logic                    w_drop_inc;
  logic signed [WIDTH-1:0] r_act  [BAND_NUM];
  logic signed [WIDTH-1:0] r_pend [BAND_NUM];

  // r_armed masks the first cycle after reset so a level already high at
  // release is seen as "old" (done_q catches up) rather than as a new rise.
  assign w_rise = i_done & ~r_done_q & r_armed;
  assign w_send = (r_state == S_SEND);
  assign w_last = (r_idx == IDX_W'(BAND_NUM - 1));
  assign w_beat = w_send & i_ready;

  assign o_valid     = w_send;
  assign o_data      = w_send ? r_act[r_idx] : '0;
  assign o_idx       = r_idx;
  assign o_last      = w_send & w_last;
  assign o_busy      = w_send | r_pend_full;
  assign o_drop_cnt  = r_drop_cnt;
  assign o_frame_cnt = r_frame_cnt;

  // Control state, trigger edge detector, index and counters.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_state     <= S_IDLE;
      r_done_q    <= 1'b0;
      r_armed     <= 1'b0;
      r_idx       <= '0;
      r_pend_full <= 1'b0;
      r_drop_cnt  <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_done_q    <= i_done;
      r_armed     <= 1'b1;
      r_idx       <= w_idx_nxt;
      r_pend_full <= w_pend_full_nxt;
      if (w_frame_inc) r_frame_cnt <= r_frame_cnt + 1'b1;
      if (w_drop_inc && (r_drop_cnt != {CNT_W{1'b1}})) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  // Next-state and buffer-steering decisions for the stream FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_pend_full_nxt = r_pend_full;
    w_ld_act_y      = 1'b0;
    w_ld_act_pend   = 1'b0;
    w_ld_pend       = 1'b0;
    w_frame_inc     = 1'b0;
    w_drop_inc      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_ld_act_y  = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (w_beat && w_last) begin
          // Frame complete: refill from pending or a same-cycle rise with no bubble.
          w_frame_inc = 1'b1;
          w_idx_nxt   = '0;
          if (r_pend_full) begin
            w_ld_act_pend = 1'b1;
            if (w_rise) w_ld_pend = 1'b1;
            else        w_pend_full_nxt = 1'b0;
          end else if (w_rise) begin
            w_ld_act_y = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          if (w_beat) w_idx_nxt = r_idx + 1'b1;
          if (w_rise) begin
            // The older pending frame wins; the newest one is discarded.
            if (r_pend_full) begin
              w_drop_inc = 1'b1;
            end else begin
              w_ld_pend       = 1'b1;
              w_pend_full_nxt = 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Frame word buffers; contents are only observed while streaming.
  always_ff @(posedge i_sys_clk) begin
    for (int b = 0; b < BAND_NUM; b++) begin
      if (w_ld_act_y)         r_act[b] <= i_y[b];
      else if (w_ld_act_pend) r_act[b] <= r_pend[b];
      if (w_ld_pend)          r_pend[b] <= i_y[b];
    end
  end

`ifdef BANDPOWER_READER_PEAK_EN
  logic [IDX_W-1:0]        w_peak_idx;
  logic signed [WIDTH-1:0] w_peak_val;
  logic [IDX_W-1:0]        r_act_pk_idx, r_pend_pk_idx;
  logic signed [WIDTH-1:0] r_act_pk_val, r_pend_pk_val;

  // Largest band by signed value; strict compare keeps the lowest index on ties.
  function automatic logic [IDX_W-1:0] f_peak_idx(input logic [BAND_NUM-1:0][WIDTH-1:0] y);
    logic [IDX_W-1:0] best;
    best = '0;
    for (int b = 1; b < BAND_NUM; b++) begin
      if ($signed(y[b]) > $signed(y[best])) best = IDX_W'(b);
    end
    return best;
  endfunction

  assign w_peak_idx = f_peak_idx(i_y);
  assign w_peak_val = i_y[w_peak_idx];
  assign o_peak_idx = w_send ? r_act_pk_idx : '0;
  assign o_peak_val = w_send ? r_act_pk_val : '0;

  // Peak travels with its frame through the same active/pending path.
  always_ff @(posedge i_sys_clk) begin
    if (w_ld_act_y) begin
      r_act_pk_idx <= w_peak_idx;
      r_act_pk_val <= w_peak_val;
    end else if (w_ld_act_pend) begin
      r_act_pk_idx <= r_pend_pk_idx;
      r_act_pk_val <= r_pend_pk_val;
    end
    if (w_ld_pend) begin
      r_pend_pk_idx <= w_peak_idx;
      r_pend_pk_val <= w_peak_val;
    end
  end
`endif

endmodule

// File: tb/tb_bandpower_reader.sv
// Directed, table-driven bench for bandpower_reader (WIDTH=12, BAND_NUM=2).
module tb_bandpower_reader;
  localparam int WIDTH    = 12;
  localparam int BAND_NUM = 2;
  localparam int CNT_W    = 8;
  localparam int IDX_W    = 1;

  logic                           clk = 1'b0;
  logic                           rst_n = 1'b0;
  logic [BAND_NUM-1:0][WIDTH-1:0] y;
  logic                           done;
  logic                           ready;
  logic signed [WIDTH-1:0]        o_data;
  logic [IDX_W-1:0]               o_idx;
  logic                           o_valid;
  logic                           o_last;
  logic                           o_busy;
  logic [CNT_W-1:0]               o_drop_cnt;
  logic [CNT_W-1:0]               o_frame_cnt;
`ifdef BANDPOWER_READER_PEAK_EN
  logic [IDX_W-1:0]               o_peak_idx;
  logic signed [WIDTH-1:0]        o_peak_val;
`endif

  bandpower_reader #(.WIDTH(WIDTH), .BAND_NUM(BAND_NUM), .CNT_W(CNT_W)) dut (
    .i_sys_clk   (clk),
    .i_sys_rst   (rst_n),
    .i_y         (y),
    .i_done      (done),
    .o_data      (o_data),
    .o_idx       (o_idx),
    .o_valid     (o_valid),
    .i_ready     (ready),
    .o_last      (o_last),
    .o_busy      (o_busy),
    .o_drop_cnt  (o_drop_cnt),
    .o_frame_cnt (o_frame_cnt)
`ifdef BANDPOWER_READER_PEAK_EN
    ,
    .o_peak_idx  (o_peak_idx),
    .o_peak_val  (o_peak_val)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int exp_frames = 0;
  int exp_drops = 0;

  typedef struct {
    int y0;
    int y1;
    int stall;
    int exp0;
    int exp1;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_y(input int v0, input int v1);
    y[0] = 12'(v0);
    y[1] = 12'(v1);
  endtask

  task automatic chk_beat(input string name, input int d, input int idx, input int last);
    chk({name, ".valid"}, int'(o_valid), 1);
    chk({name, ".data"}, int'(o_data), d);
    chk({name, ".idx"}, int'(o_idx), idx);
    chk({name, ".last"}, int'(o_last), last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int nv;
    vecs[0] = '{y0: 5,     y1: -3,   stall: 0, exp0: 5,     exp1: -3};
    vecs[1] = '{y0: 5,     y1: -3,   stall: 4, exp0: 5,     exp1: -3};
    vecs[2] = '{y0: -2048, y1: 2047, stall: 1, exp0: -2048, exp1: 2047};
    vecs[3] = '{y0: 0,     y1: -1,   stall: 2, exp0: 0,     exp1: -1};

    done  = 1'b0;
    ready = 1'b0;
    set_y(0, 0);

    // Reset state, observed while reset is asserted.
    #2;
    chk("rst.valid", int'(o_valid), 0);
    chk("rst.data", int'(o_data), 0);
    chk("rst.idx", int'(o_idx), 0);
    chk("rst.last", int'(o_last), 0);
    chk("rst.busy", int'(o_busy), 0);
    chk("rst.drop", int'(o_drop_cnt), 0);
    chk("rst.frame", int'(o_frame_cnt), 0);
    #20 rst_n = 1'b1;
    tick();
    tick();

    // Single frames with varying backpressure.
    for (int i = 0; i < 4; i++) begin
      set_y(vecs[i].y0, vecs[i].y1);
      done  = 1'b1;
      ready = 1'b0;
      tick();
      done = 1'b0;
      set_y(1234, -777);
      chk_beat($sformatf("v%0d.first", i), vecs[i].exp0, 0, 0);
      chk($sformatf("v%0d.busy", i), int'(o_busy), 1);
      for (int s = 0; s < vecs[i].stall; s++) begin
        tick();
        chk_beat($sformatf("v%0d.hold%0d", i, s), vecs[i].exp0, 0, 0);
      end
      ready = 1'b1;
      tick();
      chk_beat($sformatf("v%0d.second", i), vecs[i].exp1, 1, 1);
      tick();
      ready = 1'b0;
      exp_frames++;
      chk($sformatf("v%0d.idle", i), int'(o_valid), 0);
      chk($sformatf("v%0d.frames", i), int'(o_frame_cnt), exp_frames);
      chk($sformatf("v%0d.notbusy", i), int'(o_busy), 0);
    end

    // Pending and drop: A streams, B waits, C is dropped.
    ready = 1'b0;
    set_y(1, 2); done = 1'b1; tick(); done = 1'b0; tick();
    set_y(3, 4); done = 1'b1; tick(); done = 1'b0; tick();
    set_y(5, 6); done = 1'b1; tick(); done = 1'b0; tick();
    exp_drops++;
    chk("pend.drop", int'(o_drop_cnt), exp_drops);
    chk("pend.busy", int'(o_busy), 1);
    chk_beat("pend.a0", 1, 0, 0);
    ready = 1'b1;
    tick(); chk_beat("pend.a1", 2, 1, 1);
    tick(); chk_beat("pend.b0", 3, 0, 0);
    tick(); chk_beat("pend.b1", 4, 1, 1);
    tick();
    exp_frames += 2;
    chk("pend.idle", int'(o_valid), 0);
    chk("pend.frames", int'(o_frame_cnt), exp_frames);

    // Rise on the same edge as the last beat with pending empty.
    set_y(9, 10); done = 1'b1; tick(); done = 1'b0;
    chk_beat("sim.c0", 9, 0, 0);
    tick();
    chk_beat("sim.c1", 10, 1, 1);
    set_y(7, 8); done = 1'b1;
    tick(); done = 1'b0;
    chk_beat("sim.d0", 7, 0, 0);
    tick(); chk_beat("sim.d1", 8, 1, 1);
    tick();
    exp_frames += 2;
    chk("sim.idle", int'(o_valid), 0);
    chk("sim.drop", int'(o_drop_cnt), exp_drops);
    chk("sim.frames", int'(o_frame_cnt), exp_frames);

    // Level-held done produces exactly one frame.
    set_y(11, 12);
    done = 1'b1;
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (o_valid) nv++;
    end
    done = 1'b0;
    tick();
    exp_frames++;
    chk("level.validcycles", nv, 2);
    chk("level.frames", int'(o_frame_cnt), exp_frames);

    // Drop counter saturation while stalled.
    ready = 1'b0;
    set_y(21, 22); done = 1'b1; tick(); done = 1'b0; tick();
    set_y(23, 24); done = 1'b1; tick(); done = 1'b0; tick();
    set_y(99, 98);
    for (int k = 0; k < 260; k++) begin
      done = 1'b1; tick(); done = 1'b0; tick();
    end
    exp_drops = 255;
    chk("sat.drop", int'(o_drop_cnt), exp_drops);
    chk_beat("sat.e0", 21, 0, 0);
    ready = 1'b1;
    tick(); chk_beat("sat.e1", 22, 1, 1);
    tick(); chk_beat("sat.f0", 23, 0, 0);
    tick(); chk_beat("sat.f1", 24, 1, 1);
    tick();
    exp_frames += 2;
    chk("sat.idle", int'(o_valid), 0);
    chk("sat.frames", int'(o_frame_cnt), exp_frames);

    // Reset in the middle of a frame with done held high through release.
    ready = 1'b0;
    set_y(13, 14); done = 1'b1; tick();
    chk_beat("mid.g0", 13, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    exp_frames = 0;
    exp_drops  = 0;
    chk("mid.valid", int'(o_valid), 0);
    chk("mid.data", int'(o_data), 0);
    chk("mid.busy", int'(o_busy), 0);
    chk("mid.frames", int'(o_frame_cnt), exp_frames);
    chk("mid.drop", int'(o_drop_cnt), exp_drops);
    tick();
    tick();
    #3 rst_n = 1'b1;
    ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("rearm.noframe%0d", c), int'(o_valid), 0);
    end
    done = 1'b0;
    tick();
    chk("rearm.low", int'(o_valid), 0);
    set_y(15, -16); done = 1'b1; tick(); done = 1'b0;
    chk_beat("rearm.h0", 15, 0, 0);
    tick(); chk_beat("rearm.h1", -16, 1, 1);
    tick();
    exp_frames++;
    chk("rearm.idle", int'(o_valid), 0);
    chk("rearm.frames", int'(o_frame_cnt), exp_frames);

`ifdef BANDPOWER_READER_PEAK_EN
    // Peak band reported for the whole frame.
    ready = 1'b0;
    set_y(-2, 9); done = 1'b1; tick(); done = 1'b0;
    chk("peak1.idx.b0", int'(o_peak_idx), 1);
    chk("peak1.val.b0", int'(o_peak_val), 9);
    ready = 1'b1;
    tick();
    chk("peak1.idx.b1", int'(o_peak_idx), 1);
    chk("peak1.val.b1", int'(o_peak_val), 9);
    tick();
    set_y(4, 4); done = 1'b1; tick(); done = 1'b0;
    chk("peak2.idx.b0", int'(o_peak_idx), 0);
    chk("peak2.val.b0", int'(o_peak_val), 4);
    tick();
    chk("peak2.idx.b1", int'(o_peak_idx), 0);
    tick();
    chk("peak.idle", int'(o_peak_idx), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
